// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 encodings, ALU operations, access sizes
// and the small combinational helpers used by the core datapath.
package rv32i_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    // funct7[5] selects SUB only for register-register ops; SRA/SRAI share it.
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt, logic is_reg);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_compute(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = b;
        endcase
        return r;
    endfunction

    function automatic logic branch_cond(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        logic t;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) < $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rv32i_single_cycle_core_register_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// With STACK_INIT_EN defined, reset loads x2 with STACK_TOP instead of zero.
module register_file
    import rv32i_pkg::*;
#(
    parameter logic [31:0] STACK_TOP = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    localparam logic [31:0] X2_RESET =
`ifdef STACK_INIT_EN
        STACK_TOP;
`else
        STACK_TOP & 32'h0;
`endif

    logic [31:0] regs_w [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            localparam logic [31:0] RST_VAL = (gi == 2) ? X2_RESET : 32'h0;
            logic [31:0] q;
            // x0 has no write path, so it holds its reset value of zero forever.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= RST_VAL;
                end else if (we_i && (waddr_i == 5'(gi)) && (gi != 0)) begin
                    q <= wdata_i;
                end
            end
            assign regs_w[gi] = q;
        end
    endgenerate

    assign rdata1_o = regs_w[raddr1_i];
    assign rdata2_o = regs_w[raddr2_i];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core with unified byte-addressed memory and per-stage probes.
// Optional STACK_INIT_EN macro: reset preloads sp (x2) with BASE_ADDR+MEM_DEPTH.
module rv32i_single_cycle_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          MEM_DEPTH     = 1048576,
    parameter string       MEM_INIT_FILE = "test.hex"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] f_pc,
    output logic [31:0] f_insn,
    output logic [31:0] d_pc,
    output logic [31:0] d_imm,
    output logic [6:0]  d_opcode,
    output logic [6:0]  d_funct7,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [4:0]  d_shamt,
    output logic [2:0]  d_funct3,
    output logic        r_write_enable,
    output logic [4:0]  r_write_destination,
    output logic [4:0]  r_read_rs1,
    output logic [4:0]  r_read_rs2,
    output logic [31:0] r_write_data,
    output logic [31:0] r_read_rs1_data,
    output logic [31:0] r_read_rs2_data,
    output logic [31:0] e_pc,
    output logic [31:0] e_alu_res,
    output logic        e_br_taken,
    output logic [31:0] m_pc,
    output logic [31:0] m_address,
    output logic [31:0] m_data,
    output logic        m_rw,
    output logic [1:0]  m_size_encoded,
    output logic [31:0] w_pc,
    output logic [31:0] w_data,
    output logic        w_enable,
    output logic [4:0]  w_destination
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int WORDS = MEM_DEPTH / 4;

    logic [31:0] mem_q [WORDS];
    logic [31:0] pc_q, pc_d;

    logic [31:0] insn, imm, rs1_data, rs2_data, op_a, op_b, alu_raw, alu_res;
    logic [31:0] pc_plus4, ld_raw, ld_val, wb_data;
    logic [7:0]  f_byte [4];
    logic [7:0]  d_byte [4];
    logic [IDX_W-3:0] d_word [4];
    logic [1:0]  d_lane [4];
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        wen, is_load, is_store, is_jump, br_cond;

    // Every access is split into four byte lanes so misaligned and wrapping
    // addresses simply touch whichever words the bytes fall in.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [IDX_W-1:0] f_idx, d_idx;
            assign f_idx       = IDX_W'(pc_q - BASE_ADDR) + IDX_W'(gi);
            assign d_idx       = IDX_W'(alu_res - BASE_ADDR) + IDX_W'(gi);
            assign f_byte[gi]  = mem_q[f_idx[IDX_W-1:2]][{f_idx[1:0], 3'b000} +: 8];
            assign d_word[gi]  = d_idx[IDX_W-1:2];
            assign d_lane[gi]  = d_idx[1:0];
            assign d_byte[gi]  = mem_q[d_word[gi]][{d_lane[gi], 3'b000} +: 8];
        end
    endgenerate

    assign insn     = {f_byte[3], f_byte[2], f_byte[1], f_byte[0]};
    assign ld_raw   = {d_byte[3], d_byte[2], d_byte[1], d_byte[0]};
    assign opcode   = insn[6:0];
    assign funct3   = insn[14:12];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        imm = 32'h0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm = {insn[31:12], 12'h0};
            OPC_JAL:   imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{insn[31]}}, insn[31:20]};
            OPC_STORE: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OPC_BRANCH: imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            default:   imm = 32'h0;
        endcase
    end

    register_file #(
        .STACK_TOP(BASE_ADDR + 32'(MEM_DEPTH))
    ) u_regfile (
        .clk      (clk),
        .rst_n    (reset),
        .raddr1_i (insn[19:15]),
        .raddr2_i (insn[24:20]),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data),
        .we_i     (wen),
        .waddr_i  (insn[11:7]),
        .wdata_i  (wb_data)
    );

    always_comb begin
        alu_op   = ALU_ADD;
        op_a     = rs1_data;
        op_b     = imm;
        wen      = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jump  = 1'b0;
        br_cond  = 1'b0;
        case (opcode)
            OPC_LUI:    begin alu_op = ALU_PASSB; wen = 1'b1; end
            OPC_AUIPC:  begin op_a = pc_q; wen = 1'b1; end
            OPC_JAL:    begin op_a = pc_q; wen = 1'b1; is_jump = 1'b1; end
            OPC_JALR:   begin wen = 1'b1; is_jump = 1'b1; end
            OPC_BRANCH: begin op_a = pc_q; br_cond = branch_cond(funct3, rs1_data, rs2_data); end
            OPC_LOAD:   begin is_load = 1'b1; wen = 1'b1; end
            OPC_STORE:  is_store = 1'b1;
            OPC_OPIMM:  begin alu_op = alu_decode(funct3, insn[30], 1'b0); wen = 1'b1; end
            OPC_OP:     begin op_b = rs2_data; alu_op = alu_decode(funct3, insn[30], 1'b1); wen = 1'b1; end
            default:    ;
        endcase
    end

    assign alu_raw = alu_compute(alu_op, op_a, op_b);
    assign alu_res = (opcode == OPC_JALR) ? {alu_raw[31:1], 1'b0} : alu_raw;

    always_comb begin
        case (funct3)
            F3_LB:   ld_val = {{24{ld_raw[7]}}, ld_raw[7:0]};
            F3_LH:   ld_val = {{16{ld_raw[15]}}, ld_raw[15:0]};
            F3_LBU:  ld_val = {24'h0, ld_raw[7:0]};
            F3_LHU:  ld_val = {16'h0, ld_raw[15:0]};
            default: ld_val = ld_raw;
        endcase
    end

    assign wb_data = is_load ? ld_val : (is_jump ? pc_plus4 : alu_res);
    assign pc_d    = (is_jump || br_cond) ? alu_res : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= BASE_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Memory has no reset; the reset term only suppresses a store while reset is held.
    always_ff @(posedge clk) begin
        if (reset && is_store) begin
            for (int k = 0; k < 4; k++) begin
                if ((funct3[1:0] == SIZE_WORD) || (k == 0) ||
                    ((funct3[1:0] == SIZE_HALF) && (k == 1))) begin
                    mem_q[d_word[k]][{d_lane[k], 3'b000} +: 8] <= rs2_data[8*k +: 8];
                end
            end
        end
    end

    assign f_pc                = pc_q;
    assign f_insn              = insn;
    assign d_pc                = pc_q;
    assign d_imm               = imm;
    assign d_opcode            = opcode;
    assign d_funct7            = insn[31:25];
    assign d_rd                = insn[11:7];
    assign d_rs1               = insn[19:15];
    assign d_rs2               = insn[24:20];
    assign d_shamt             = insn[24:20];
    assign d_funct3            = funct3;
    assign r_write_enable      = wen;
    assign r_write_destination = insn[11:7];
    assign r_write_data        = wb_data;
    assign r_read_rs1          = insn[19:15];
    assign r_read_rs2          = insn[24:20];
    assign r_read_rs1_data     = rs1_data;
    assign r_read_rs2_data     = rs2_data;
    assign e_pc                = pc_q;
    assign e_alu_res           = alu_res;
    assign e_br_taken          = is_jump || br_cond;
    assign m_pc                = pc_q;
    assign m_address           = alu_res;
    assign m_data              = is_store ? rs2_data : (is_load ? ld_raw : 32'h0);
    assign m_rw                = is_store;
    assign m_size_encoded      = funct3[1:0];
    assign w_pc                = pc_q;
    assign w_data              = wb_data;
    assign w_enable            = wen;
    assign w_destination       = insn[11:7];

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Self-checking bench: loads a short program into core memory, queues the expected
// per-instruction results and compares every retired instruction against them.
module tb_rv32i_single_cycle_core;

    localparam logic [31:0] BASE = 32'h0100_0000;
`ifdef STACK_INIT_EN
    localparam logic [31:0] SP_EXP = 32'h0110_0000;
`else
    localparam logic [31:0] SP_EXP = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] f_pc, f_insn, d_pc, d_imm, r_write_data, r_read_rs1_data, r_read_rs2_data;
    logic [31:0] e_pc, e_alu_res, m_pc, m_address, m_data, w_pc, w_data;
    logic [6:0]  d_opcode, d_funct7;
    logic [4:0]  d_rd, d_rs1, d_rs2, d_shamt, r_write_destination, r_read_rs1, r_read_rs2, w_destination;
    logic [2:0]  d_funct3;
    logic        r_write_enable, e_br_taken, m_rw, w_enable;
    logic [1:0]  m_size_encoded;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32i_single_cycle_core #(
        .BASE_ADDR(BASE), .MEM_DEPTH(1048576), .MEM_INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .f_pc(f_pc), .f_insn(f_insn),
        .d_pc(d_pc), .d_imm(d_imm), .d_opcode(d_opcode), .d_funct7(d_funct7),
        .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_shamt(d_shamt), .d_funct3(d_funct3),
        .r_write_enable(r_write_enable), .r_write_destination(r_write_destination),
        .r_read_rs1(r_read_rs1), .r_read_rs2(r_read_rs2), .r_write_data(r_write_data),
        .r_read_rs1_data(r_read_rs1_data), .r_read_rs2_data(r_read_rs2_data),
        .e_pc(e_pc), .e_alu_res(e_alu_res), .e_br_taken(e_br_taken),
        .m_pc(m_pc), .m_address(m_address), .m_data(m_data), .m_rw(m_rw),
        .m_size_encoded(m_size_encoded),
        .w_pc(w_pc), .w_data(w_data), .w_enable(w_enable), .w_destination(w_destination)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wdst;
        logic [31:0] wdata;
        logic        br;
        logic        chk_alu;
        logic [31:0] alu;
        logic        rw;
        logic        chk_mem;
        logic [1:0]  msize;
        logic [31:0] mdata;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] off, input logic wen,
                        input logic [4:0] wdst, input logic [31:0] wdata, input logic br,
                        input logic chk_alu, input logic [31:0] alu, input logic rw,
                        input logic chk_mem, input logic [1:0] msize, input logic [31:0] mdata);
        exp_t e;
        e.tag = tag; e.pc = BASE + off; e.wen = wen; e.wdst = wdst; e.wdata = wdata;
        e.br = br; e.chk_alu = chk_alu; e.alu = alu; e.rw = rw;
        e.chk_mem = chk_mem; e.msize = msize; e.mdata = mdata;
        exp_q.push_back(e);
    endtask

    logic [31:0] prog [27] = '{
        32'hFFD00293, 32'h80FF11B7, 32'h23418193, 32'h01000237,
        32'h10322023, 32'h10020303, 32'h10124383, 32'h10221403,
        32'h00700093, 32'h00508463, 32'h00C004EF, 32'h00C0006F,
        32'h00000013, 32'hFE108CE3, 32'h04120313, 32'h004300E7,
        32'h00000013, 32'h00500013, 32'h000005B3, 32'h00010613,
        32'h10522223, 32'h10422683, 32'h001282B3, 32'h00028713,
        32'h4041D793, 32'h00000073, 32'h0000006F
    };

    initial begin
        exp_t e;
        for (int i = 0; i < 27; i++) dut.mem_q[i] = prog[i];
        for (int i = 64; i < 68; i++) dut.mem_q[i] = 32'h0;

        //    tag          off    wen dst wdata         br chkA alu            rw chkM sz mdata
        push("addi_neg",  'h00, 1, 5,  32'hFFFFFFFD, 0, 1, 32'hFFFFFFFD, 0, 0, 0, 0);
        push("lui_x3",    'h04, 1, 3,  32'h80FF1000, 0, 0, 0,            0, 0, 0, 0);
        push("addi_x3",   'h08, 1, 3,  32'h80FF1234, 0, 0, 0,            0, 0, 0, 0);
        push("lui_x4",    'h0C, 1, 4,  32'h01000000, 0, 0, 0,            0, 0, 0, 0);
        push("sw_word",   'h10, 0, 0,  0,            0, 1, 32'h01000100, 1, 1, 2, 32'h80FF1234);
        push("lb",        'h14, 1, 6,  32'h00000034, 0, 1, 32'h01000100, 0, 1, 0, 32'h80FF1234);
        push("lbu",       'h18, 1, 7,  32'h00000012, 0, 1, 32'h01000101, 0, 1, 0, 32'h0080FF12);
        push("lh",        'h1C, 1, 8,  32'hFFFF80FF, 0, 1, 32'h01000102, 0, 1, 1, 32'h000080FF);
        push("addi_x1",   'h20, 1, 1,  32'h00000007, 0, 0, 0,            0, 0, 0, 0);
        push("beq_ne",    'h24, 0, 0,  0,            0, 1, 32'h0100002C, 0, 0, 0, 0);
        push("jal_x9",    'h28, 1, 9,  32'h0100002C, 1, 1, 32'h01000034, 0, 0, 0, 0);
        push("beq_back",  'h34, 0, 0,  0,            1, 1, 32'h0100002C, 0, 0, 0, 0);
        push("jal_x0",    'h2C, 1, 0,  32'h01000030, 1, 1, 32'h01000038, 0, 0, 0, 0);
        push("addi_x6",   'h38, 1, 6,  32'h01000041, 0, 0, 0,            0, 0, 0, 0);
        push("jalr",      'h3C, 1, 1,  32'h01000040, 1, 1, 32'h01000044, 0, 0, 0, 0);
        push("addi_x0",   'h44, 1, 0,  32'h00000005, 0, 0, 0,            0, 0, 0, 0);
        push("add_x0x0",  'h48, 1, 11, 32'h00000000, 0, 0, 0,            0, 0, 0, 0);
        push("read_sp",   'h4C, 1, 12, SP_EXP,       0, 0, 0,            0, 0, 0, 0);
        push("sw_x5",     'h50, 0, 0,  0,            0, 1, 32'h01000104, 1, 1, 2, 32'hFFFFFFFD);
        push("lw_after",  'h54, 1, 13, 32'hFFFFFFFD, 0, 1, 32'h01000104, 0, 1, 2, 32'hFFFFFFFD);
        push("add_rw",    'h58, 1, 5,  32'h0100003D, 0, 0, 0,            0, 0, 0, 0);
        push("new_x5",    'h5C, 1, 14, 32'h0100003D, 0, 0, 0,            0, 0, 0, 0);
        push("srai",      'h60, 1, 15, 32'hF80FF123, 0, 0, 0,            0, 0, 0, 0);
        push("ecall",     'h64, 0, 0,  0,            0, 0, 0,            0, 0, 0, 0);
        push("jal_self",  'h68, 1, 0,  32'h0100006C, 1, 1, 32'h01000068, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", f_pc, BASE);
        reset = 1'b1;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".pc"}, f_pc, e.pc);
            check({e.tag, ".wen"}, {31'b0, w_enable}, {31'b0, e.wen});
            check({e.tag, ".rw"}, {31'b0, m_rw}, {31'b0, e.rw});
            check({e.tag, ".br"}, {31'b0, e_br_taken}, {31'b0, e.br});
            if (e.wen) begin
                check({e.tag, ".wdst"}, {27'b0, w_destination}, {27'b0, e.wdst});
                check({e.tag, ".wdata"}, w_data, e.wdata);
                check({e.tag, ".rwdata"}, r_write_data, e.wdata);
            end
            if (e.chk_alu) check({e.tag, ".alu"}, e_alu_res, e.alu);
            if (e.chk_mem) begin
                check({e.tag, ".msize"}, {30'b0, m_size_encoded}, {30'b0, e.msize});
                check({e.tag, ".mdata"}, m_data, e.mdata);
            end
            if (e.tag == "addi_neg") check("addi_neg.imm", d_imm, 32'hFFFFFFFD);
            if (e.tag == "add_x0x0") check("x0_reads_zero", r_read_rs1_data, 32'h0);
            $display("[TB] pc=%h insn=%h %s wen=%0d rd=%0d wdata=%h", f_pc, f_insn, e.tag,
                     w_enable, w_destination, w_data);
            @(posedge clk);
            #1;
        end

        check("loop_pc", f_pc, BASE + 32'h68);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_pc_async", f_pc, BASE);
        @(posedge clk);
        #1;
        check("midrst_pc_hold", f_pc, BASE);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart_insn", f_insn, 32'hFFD00293);
        check("restart_wdata", w_data, 32'hFFFFFFFD);
        @(posedge clk);
        #1;
        check("restart_pc4", f_pc, BASE + 32'h4);
        $display("[TB] pc=%h insn=%h restart after mid-run reset", f_pc, f_insn);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
